// File: rtl/hazard_bypass_ctrl.sv
// Hazard and bypass controller for the 5-stage pipeline: XM/MW operand forwarding,
// lw->sw store-data bypass, load-use stall and a scoreboard for the multi-cycle mult/div unit.
module hazard_bypass_ctrl #(
  parameter int REG_AW     = 5,
  parameter int MD_LATENCY = 17,
  parameter int FWD_R0     = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       fd_ir,
  input  logic [31:0]       dx_ir,
  input  logic [31:0]       xm_ir,
  input  logic [31:0]       mw_ir,
  input  logic              flush,
  output logic [1:0]        a_sel,
  output logic [1:0]        b_sel,
  output logic              mem_sel,
  output logic              stall,
  output logic              md_busy,
  output logic [REG_AW-1:0] md_rd,
  output logic              md_done,
  output logic              dbg_md_state
);

  localparam int CW = $clog2(MD_LATENCY);

  typedef enum logic {MD_IDLE = 1'b0, MD_BUSY = 1'b1} md_state_e;

  md_state_e         state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [REG_AW-1:0] md_rd_q, md_rd_d;

  function automatic logic [4:0] op_of(input logic [31:0] ir);
    return ir[31:27];
  endfunction

  function automatic logic [REG_AW-1:0] rd_of(input logic [31:0] ir);
    return ir[22 +: REG_AW];
  endfunction

  function automatic logic [REG_AW-1:0] rs_of(input logic [31:0] ir);
    return ir[17 +: REG_AW];
  endfunction

  function automatic logic [REG_AW-1:0] rt_of(input logic [31:0] ir);
    return ir[12 +: REG_AW];
  endfunction

  function automatic logic writes(input logic [31:0] ir);
    return (op_of(ir) == 5'd0) || (op_of(ir) == 5'd5) || (op_of(ir) == 5'd8);
  endfunction

  function automatic logic is_md(input logic [31:0] ir);
    return (op_of(ir) == 5'd0) && ((ir[6:2] == 5'd6) || (ir[6:2] == 5'd7));
  endfunction

  // Register may take part in a match: r0 is excluded unless FWD_R0 is set.
  function automatic logic live(input logic [REG_AW-1:0] r);
    return (FWD_R0 != 0) || (r != '0);
  endfunction

  // {valid, register} of the A-side source operand
  function automatic logic [REG_AW:0] src_a(input logic [31:0] ir);
    case (op_of(ir))
      5'd0, 5'd5, 5'd7, 5'd8: return {1'b1, rs_of(ir)};
      5'd2, 5'd4, 5'd6:       return {1'b1, rd_of(ir)};
      default:                return '0;
    endcase
  endfunction

  function automatic logic [REG_AW:0] src_b(input logic [31:0] ir);
    case (op_of(ir))
      5'd0:       return {1'b1, rt_of(ir)};
      5'd7, 5'd8: return {1'b1, rd_of(ir)};
      5'd2, 5'd6: return {1'b1, rs_of(ir)};
      default:    return '0;
    endcase
  endfunction

  logic [REG_AW:0] dx_a, dx_b, fd_a, fd_b;
  logic            xm_wr, mw_wr;
  logic            lu_stall, md_stall, issue;
  logic            unused_ir_bits;

  assign dx_a  = src_a(dx_ir);
  assign dx_b  = src_b(dx_ir);
  assign fd_a  = src_a(fd_ir);
  assign fd_b  = src_b(fd_ir);
  assign xm_wr = writes(xm_ir) && live(rd_of(xm_ir));
  assign mw_wr = writes(mw_ir) && live(rd_of(mw_ir));
  assign unused_ir_bits = ^{fd_ir, dx_ir, xm_ir, mw_ir};

  // XM result is newer than MW, so it takes priority.
  always_comb begin
    a_sel = 2'b00;
    b_sel = 2'b00;
    if (dx_a[REG_AW] && xm_wr && rd_of(xm_ir) == dx_a[REG_AW-1:0])      a_sel = 2'b01;
    else if (dx_a[REG_AW] && mw_wr && rd_of(mw_ir) == dx_a[REG_AW-1:0]) a_sel = 2'b10;
    if (dx_b[REG_AW] && xm_wr && rd_of(xm_ir) == dx_b[REG_AW-1:0])      b_sel = 2'b01;
    else if (dx_b[REG_AW] && mw_wr && rd_of(mw_ir) == dx_b[REG_AW-1:0]) b_sel = 2'b10;
  end

  assign mem_sel = (op_of(mw_ir) == 5'd8) && (op_of(xm_ir) == 5'd7) &&
                   (rd_of(mw_ir) == rd_of(xm_ir)) && live(rd_of(mw_ir));

  // A store's data field is excluded: mem_sel covers a load feeding store data.
  always_comb begin
    lu_stall = 1'b0;
    if (op_of(dx_ir) == 5'd8 && rd_of(dx_ir) != '0) begin
      if (fd_a[REG_AW] && fd_a[REG_AW-1:0] == rd_of(dx_ir)) lu_stall = 1'b1;
      if (op_of(fd_ir) != 5'd7 && fd_b[REG_AW] && fd_b[REG_AW-1:0] == rd_of(dx_ir))
        lu_stall = 1'b1;
    end
  end

  always_comb begin
    md_stall = 1'b0;
    if (state_q == MD_BUSY) begin
      if (is_md(fd_ir)) md_stall = 1'b1;
      if (live(md_rd_q)) begin
        if (fd_a[REG_AW] && fd_a[REG_AW-1:0] == md_rd_q) md_stall = 1'b1;
        if (fd_b[REG_AW] && fd_b[REG_AW-1:0] == md_rd_q) md_stall = 1'b1;
        if (writes(fd_ir) && rd_of(fd_ir) == md_rd_q)    md_stall = 1'b1;
      end
    end
  end

  assign stall = lu_stall || md_stall;
  assign issue = is_md(dx_ir) && !flush && !stall;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= MD_IDLE;
      count_q <= '0;
      md_rd_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      md_rd_q <= md_rd_d;
    end
  end

  // A new op may issue in the done cycle; an in-flight op is never cancelled.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    md_rd_d = md_rd_q;
    case (state_q)
      MD_IDLE: begin
        if (issue) begin
          state_d = MD_BUSY;
          count_d = CW'(MD_LATENCY - 1);
          md_rd_d = rd_of(dx_ir);
        end
      end
      MD_BUSY: begin
        if (count_q == '0) begin
          if (issue) begin
            count_d = CW'(MD_LATENCY - 1);
            md_rd_d = rd_of(dx_ir);
          end else begin
            state_d = MD_IDLE;
          end
        end else begin
          count_d = count_q - CW'(1);
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_comb begin
    md_busy      = (state_q == MD_BUSY);
    md_done      = (state_q == MD_BUSY) && (count_q == '0);
    md_rd        = md_rd_q;
    dbg_md_state = state_q;
  end

endmodule

// File: tb/tb_hazard_bypass_ctrl.sv
// Directed bench for hazard_bypass_ctrl with MD_LATENCY=4, FWD_R0=0; expected
// values are hand-derived from the pipeline rules.
module tb_hazard_bypass_ctrl;

  logic        clock;
  logic        reset;
  logic [31:0] fd_ir, dx_ir, xm_ir, mw_ir;
  logic        flush;
  logic [1:0]  a_sel, b_sel;
  logic        mem_sel, stall, md_busy, md_done, dbg_md_state;
  logic [4:0]  md_rd;

  int checks = 0;
  int errors = 0;

  hazard_bypass_ctrl #(.REG_AW(5), .MD_LATENCY(4), .FWD_R0(0)) dut (
    .clock(clock), .reset(reset),
    .fd_ir(fd_ir), .dx_ir(dx_ir), .xm_ir(xm_ir), .mw_ir(mw_ir),
    .flush(flush),
    .a_sel(a_sel), .b_sel(b_sel), .mem_sel(mem_sel), .stall(stall),
    .md_busy(md_busy), .md_rd(md_rd), .md_done(md_done),
    .dbg_md_state(dbg_md_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

  localparam logic [31:0] NOP = 32'h0;

  function automatic logic [31:0] ins(input logic [4:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] sub);
    return {op, rd, rs, rt, 5'd0, sub, 2'd0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    fd_ir = NOP; dx_ir = NOP; xm_ir = NOP; mw_ir = NOP;
    tick();
    tick();
    #1;
    chk("rst_busy", 32'(md_busy), 32'd0);
    chk("rst_done", 32'(md_done), 32'd0);
    chk("rst_md_rd", 32'(md_rd), 32'd0);
    chk("rst_state", 32'(dbg_md_state), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    reset = 1'b1;
    tick();

    // Forwarding priority
    xm_ir = ins(5'd0, 5'd3, 5'd1, 5'd2, 5'd0);
    mw_ir = ins(5'd5, 5'd3, 5'd1, 5'd0, 5'd0);
    dx_ir = ins(5'd0, 5'd5, 5'd3, 5'd3, 5'd0);
    #1;
    chk("fwd_xm_a", 32'(a_sel), 32'd1);
    chk("fwd_xm_b", 32'(b_sel), 32'd1);
    xm_ir = ins(5'd7, 5'd3, 5'd1, 5'd0, 5'd0);
    #1;
    chk("fwd_mw_a", 32'(a_sel), 32'd2);
    chk("fwd_mw_b", 32'(b_sel), 32'd2);
    mw_ir = NOP;
    #1;
    chk("fwd_none_a", 32'(a_sel), 32'd0);
    xm_ir = ins(5'd0, 5'd3, 5'd1, 5'd2, 5'd0);
    dx_ir = ins(5'd2, 5'd3, 5'd9, 5'd0, 5'd0);
    #1;
    chk("fwd_br_a", 32'(a_sel), 32'd1);
    chk("fwd_br_b", 32'(b_sel), 32'd0);
    xm_ir = ins(5'd0, 5'd0, 5'd1, 5'd2, 5'd0);
    mw_ir = ins(5'd5, 5'd0, 5'd1, 5'd0, 5'd0);
    dx_ir = ins(5'd0, 5'd5, 5'd0, 5'd0, 5'd0);
    #1;
    chk("fwd_r0_a", 32'(a_sel), 32'd0);
    chk("fwd_r0_b", 32'(b_sel), 32'd0);

    // Store-data bypass
    mw_ir = ins(5'd8, 5'd9, 5'd1, 5'd0, 5'd0);
    xm_ir = ins(5'd7, 5'd9, 5'd2, 5'd0, 5'd0);
    dx_ir = NOP;
    #1;
    chk("mem_sel_hit", 32'(mem_sel), 32'd1);
    xm_ir = ins(5'd7, 5'd8, 5'd2, 5'd0, 5'd0);
    #1;
    chk("mem_sel_diff", 32'(mem_sel), 32'd0);
    mw_ir = ins(5'd8, 5'd0, 5'd1, 5'd0, 5'd0);
    xm_ir = ins(5'd7, 5'd0, 5'd2, 5'd0, 5'd0);
    #1;
    chk("mem_sel_r0", 32'(mem_sel), 32'd0);
    xm_ir = NOP; mw_ir = NOP;

    // Load-use
    tick();
    dx_ir = ins(5'd8, 5'd4, 5'd1, 5'd0, 5'd0);
    fd_ir = ins(5'd0, 5'd6, 5'd4, 5'd2, 5'd0);
    #1;
    chk("lu_add", 32'(stall), 32'd1);
    tick();
    dx_ir = NOP;
    #1;
    chk("lu_one_cycle", 32'(stall), 32'd0);
    dx_ir = ins(5'd8, 5'd4, 5'd1, 5'd0, 5'd0);
    fd_ir = ins(5'd7, 5'd4, 5'd7, 5'd0, 5'd0);
    #1;
    chk("lu_sw_data", 32'(stall), 32'd0);
    fd_ir = ins(5'd7, 5'd7, 5'd4, 5'd0, 5'd0);
    #1;
    chk("lu_sw_addr", 32'(stall), 32'd1);
    dx_ir = ins(5'd8, 5'd0, 5'd1, 5'd0, 5'd0);
    fd_ir = ins(5'd0, 5'd6, 5'd0, 5'd2, 5'd0);
    #1;
    chk("lu_r0", 32'(stall), 32'd0);
    dx_ir = NOP; fd_ir = NOP;

    // mul r8 issues at cycle 0
    tick();
    dx_ir = ins(5'd0, 5'd8, 5'd1, 5'd2, 5'd6);
    #1;
    chk("md_c0_busy", 32'(md_busy), 32'd0);
    tick();
    dx_ir = NOP;
    #1;
    chk("md_c1_busy", 32'(md_busy), 32'd1);
    chk("md_c1_rd", 32'(md_rd), 32'd8);
    chk("md_c1_done", 32'(md_done), 32'd0);
    chk("md_c1_stall", 32'(stall), 32'd0);
    tick();
    fd_ir = ins(5'd0, 5'd1, 5'd8, 5'd2, 5'd0);
    #1;
    chk("md_c2_stall", 32'(stall), 32'd1);
    chk("md_c2_done", 32'(md_done), 32'd0);
    tick();
    chk("md_c3_stall", 32'(stall), 32'd1);
    chk("md_c3_done", 32'(md_done), 32'd0);
    tick();
    chk("md_c4_stall", 32'(stall), 32'd1);
    chk("md_c4_done", 32'(md_done), 32'd1);
    chk("md_c4_busy", 32'(md_busy), 32'd1);
    tick();
    chk("md_c5_busy", 32'(md_busy), 32'd0);
    chk("md_c5_done", 32'(md_done), 32'd0);
    chk("md_c5_stall", 32'(stall), 32'd0);
    fd_ir = NOP;

    // Flush suppresses issue
    dx_ir = ins(5'd0, 5'd8, 5'd1, 5'd2, 5'd6);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    dx_ir = NOP;
    #1;
    chk("flush_busy", 32'(md_busy), 32'd0);

    // Reset during busy
    dx_ir = ins(5'd0, 5'd8, 5'd1, 5'd2, 5'd7);
    tick();
    dx_ir = NOP;
    #1;
    chk("rb_busy", 32'(md_busy), 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk("rb_busy_clr", 32'(md_busy), 32'd0);
    chk("rb_md_rd", 32'(md_rd), 32'd0);
    chk("rb_state", 32'(dbg_md_state), 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("rb_no_done", 32'(md_done), 32'd0);
      tick();
    end

    // Back-to-back div
    dx_ir = ins(5'd0, 5'd8, 5'd1, 5'd2, 5'd7);
    #1;
    tick();
    dx_ir = NOP;
    #1;
    chk("bb_c1_busy", 32'(md_busy), 32'd1);
    tick();
    fd_ir = ins(5'd5, 5'd8, 5'd1, 5'd0, 5'd0);
    #1;
    chk("bb_waw_stall", 32'(stall), 32'd1);
    tick();
    fd_ir = ins(5'd0, 5'd11, 5'd1, 5'd2, 5'd6);
    #1;
    chk("bb_md_fd_stall", 32'(stall), 32'd1);
    tick();
    fd_ir = NOP;
    dx_ir = ins(5'd0, 5'd10, 5'd1, 5'd2, 5'd7);
    #1;
    chk("bb_c4_done", 32'(md_done), 32'd1);
    chk("bb_c4_stall", 32'(stall), 32'd0);
    tick();
    dx_ir = NOP;
    #1;
    chk("bb_c5_busy", 32'(md_busy), 32'd1);
    chk("bb_c5_rd", 32'(md_rd), 32'd10);
    chk("bb_c5_done", 32'(md_done), 32'd0);
    tick();
    chk("bb_c6_done", 32'(md_done), 32'd0);
    tick();
    chk("bb_c7_done", 32'(md_done), 32'd0);
    tick();
    chk("bb_c8_done", 32'(md_done), 32'd1);
    chk("bb_c8_busy", 32'(md_busy), 32'd1);
    tick();
    chk("bb_c9_busy", 32'(md_busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_bypass_ctrl.md
Name: hazard_bypass_ctrl

Overview:
- Next-generation hazard and bypass controller for the 5-stage pipeline.
- Keeps XM/MW operand bypass selection and the lw→sw memory-data bypass, with register-address width parameterised and r0 excluded from forwarding.
- Adds sequential hazard handling: load-use stall detection and a scoreboard for the multi-cycle mult/div unit.
- Sits beside the F/D and D/X latches; drives the ALU operand muxes, the data-memory input mux, and the F/D/PC stall enables.

Parameters:
- REG_AW, 5, register address width; rd = IR[26:22], rs = IR[21:17], rt = IR[16:12] when 5 (field positions fixed for 32-bit IR).
- MD_LATENCY, 17, cycles from mult/div issue in DX to result ready (≥2).
- FWD_R0, 0, 0 = never forward or stall on register 0; 1 = treat r0 like any register.

Ports:
- clock  in  1  pipeline clock, rising edge
- reset  in  1  synchronous, active-low
- fd_ir  in  32  instruction in F/D latch
- dx_ir  in  32  instruction in D/X latch
- xm_ir  in  32  instruction in X/M latch
- mw_ir  in  32  instruction in M/W latch
- flush  in  1  branch/jump taken this cycle; DX contents are squashed
- a_sel  out  2  ALU A operand: 00 regfile, 01 XM result, 10 MW result
- b_sel  out  2  ALU B operand, same encoding as a_sel
- mem_sel  out  1  store data taken from MW (lw→sw bypass)
- stall  out  1  hold PC and F/D, inject nop into D/X
- md_busy  out  1  mult/div operation outstanding
- md_rd  out  REG_AW  destination of outstanding mult/div
- md_done  out  1  one-cycle pulse: mult/div result ready

Behaviour:
- Opcode is IR[31:27]; ALU subop is IR[6:2].
- Register writers: opcodes 0 (ALU), 5 (addi), 8 (lw).
- Source fields by opcode:
  - A source: rs for opcodes 0/5/7/8; rd for 2/6 (branches) and 4 (jr).
  - B source: rt for opcode 0; rd for 7/8; rs for 2/6.
- Forwarding is combinational:
  - XM match (XM writes, XM rd == source) → 01.
  - Otherwise MW match → 10.
  - Otherwise 00. XM always wins; 11 is never driven.
  - With FWD_R0=0, a source or destination of 0 never matches.
- mem_sel = MW op 8 & XM op 7 & MW rd == XM rd (and rd ≠ 0 when FWD_R0=0).
- Load-use stall (combinational):
  - Asserted when DX op is 8, DX rd ≠ 0, and DX rd equals an A or B source of fd_ir.
  - Exception: no stall when the only match is the rd (data) field of an FD sw; mem_sel covers that case.
- Mult/div start: DX op 0 with subop 6 or 7, flush = 0, stall = 0 → issue.
- State machine (registered):
  - MD_IDLE: on issue, latch md_rd ← DX rd and count ← MD_LATENCY−1, then go to MD_BUSY.
  - MD_BUSY: count decrements each cycle. At count = 0, md_done = 1 for that cycle and the next state is MD_IDLE.
  - md_busy = 1 throughout MD_BUSY, including the md_done cycle.
  - The issue instruction's own cycle is not busy.
- Mult/div stall, while md_busy and any of the following hold:
  - FD reads md_rd (RAW).
  - FD writes md_rd (WAW).
  - FD is itself a mult/div.
  - md_rd = 0 (with FWD_R0=0) suppresses the RAW/WAW terms only.
- stall = load-use term OR mult/div term.
- Simultaneous events:
  - flush during issue → no issue.
  - flush while MD_BUSY → operation continues; an already-issued op is never cancelled.
  - A new mult/div in DX in the md_done cycle is legal: the state reloads directly into MD_BUSY with the new rd and a fresh count.
- Reset (reset=0 at clock edge, including mid-operation): MD_IDLE, count 0, md_rd 0; md_busy and md_done = 0. Combinational outputs follow their inputs with state reset.

Test Plan:
- XM: add r3; MW: addi r3; DX: add r5,r3,r3 → a_sel = b_sel = 01 (XM priority); with the XM IR changed to sw → a_sel = b_sel = 10.
- DX: lw r4; FD: add r6,r4,r2 → stall = 1 for exactly one cycle. FD: sw r4,0(r7) → stall = 0. FD: sw r7,0(r4) → stall = 1. DX: lw r0 → stall = 0.
- MW: lw r9; XM: sw r9 → mem_sel = 1; MW: lw r0, XM: sw r0 → mem_sel = 0 (FWD_R0=0).
- MD_LATENCY=4: mul r8 issues at cycle 0 → md_busy cycles 1–4, md_done at cycle 4, md_rd = 8. FD add r1,r8,r2 in cycle 2 → stall = 1 until md_done cycle inclusive.
- mul in DX with flush = 1 → md_busy stays 0. During busy, pull reset low for one edge → md_busy = 0, md_done never pulses.
- Back-to-back: second div in DX in the md_done cycle → md_busy stays 1 continuously, md_rd updates, md_done again MD_LATENCY cycles later.
